isqrt_pipe: RTL and testbench
=============================

// Module: isqrt_pipe
// PURPOSE
//  Pipelined integer square root: y = floor(sqrt(x)) for a 32-bit unsigned x.
//  Sits directly downstream of the formula FSMs and consumes their isqrt_x_vld/isqrt_x.
//  It returns isqrt_y_vld/isqrt_y to them after a fixed latency of N_STAGES cycles.
//  Fully pipelined: accepts one argument per cycle, has no backpressure and never reorders.
// PARAMETERS
//  N_STAGES  4  register stages (latency); legal values 1,2,4,8,16; ITERS_PER_STAGE = 16/N_STAGES
// PORTS
//  clk    in   1   single clock; all state updates on posedge
//  rst    in   1   synchronous, active-low reset
//  x_vld  in   1   argument valid; sampled every cycle
//  x      in   32  unsigned radicand; ignored when x_vld=0
//  y_vld  out  1   result valid, exactly N_STAGES cycles after the matching x_vld
//  y      out  16  floor(sqrt(x)); holds its last value while y_vld=0
// BEHAVIOUR
//  - Reset: rst=0 at a posedge clears every stage valid bit and every data register.
//    After reset, y_vld=0 and y=0.
//  - Reset mid-operation: in-flight arguments are discarded. No y_vld pulses for them after rst.
//  - Algorithm: restoring digit-by-digit root, 16 iterations. Iteration i = 15..0:
//      rem   = (rem << 2) | x[2i+1:2i]
//      trial = (root << 2) | 1
//      if rem >= trial: rem -= trial; root = (root << 1) | 1; else root = root << 1
//    Initial values: rem = 0, root = 0.
//    Widths: rem is 18 bits, trial 18 bits, root 16 bits. No overflow is possible (rem <= 2*root+1).
//  - Stage k (k=0..N_STAGES-1) runs ITERS_PER_STAGE iterations combinationally, then registers:
//    vld, root, rem and the remaining unconsumed radicand bits.
//  - Valid chain: a shift register of N_STAGES bits. vld[0] <= x_vld, vld[k] <= vld[k-1].
//    Output y_vld = vld[N_STAGES-1].
//  - Data registers of stage k load only when the incoming valid is 1; otherwise they hold.
//    As a result, y changes only together with y_vld=1 and holds between results.
//  - Throughput: 1 per cycle. Back-to-back, sparse and bubbled inputs emerge with the same spacing.
//  - Simultaneous events: when rst=0, reset wins over x_vld=1 in the same cycle; that argument is dropped.
//  - Boundaries: x=0 -> y=0; x=32'hFFFF_FFFF -> y=16'hFFFF.
//    Perfect squares are exact; x = s*s - 1 yields s-1.
//  - No combinational path from x/x_vld to y/y_vld for any legal N_STAGES.
//  - Elaboration: N_STAGES not dividing 16, or outside 1..16, is a fatal error.
// STRUCTURE
//  - Package isqrt_pkg:
//      localparams ISQRT_X_W=32, ISQRT_Y_W=16, ISQRT_REM_W=18;
//      typedef struct packed {root, rem, xrem} isqrt_stage_t;
//      function isqrt_step(isqrt_stage_t) implementing one iteration.
//  - Sub-module isqrt_stage, parameterised by ITERS: combinational iterations plus one register slice with a valid bit.
//    isqrt_pipe is a generate loop of N_STAGES isqrt_stage instances.
// TESTING
//  1. Reset: hold rst=0 for 3 cycles with x_vld=1, x=100 -> y_vld=0, y=0 throughout and for N_STAGES cycles after release.
//  2. Single values, one per idle gap: x=0->0, 1->1, 15->3, 16->4, 1_000_000->1000, 32'hFFFF_FFFF->16'hFFFF.
//     Each y_vld arrives exactly N_STAGES cycles after x_vld.
//  3. Back-to-back: x=16,25,1_000_000 on 3 consecutive cycles.
//     Expect y=4,5,1000 on cycles N_STAGES, N_STAGES+1, N_STAGES+2 with y_vld high for all three.
//  4. Bubbles: x_vld pattern 1,0,1,1,0,0,1 with x=49,999,64,81,7,7,2.
//     Expect the same y_vld pattern delayed by N_STAGES, with y=7,8,9,1. y holds between pulses.
//  5. Reset mid-flight: issue x=9,16 back-to-back, then assert rst=0 one cycle later.
//     Expect no y_vld for either. x=36 after release -> y=6.
//  6. Random: 10k random x at 50% valid density, run for N_STAGES = 1, 4 and 16.
//     Compare against a floor($sqrt) reference model; also check latency and ordering.

Source files
------------

// File: rtl/isqrt_pkg.sv
// isqrt_pkg: widths, per-stage state and one digit-by-digit root iteration
package isqrt_pkg;
  localparam int ISQRT_X_W = 32;
  localparam int ISQRT_Y_W = 16;
  localparam int ISQRT_REM_W = 18;
  typedef struct packed {
    logic [ISQRT_Y_W-1:0]   root;
    logic [ISQRT_REM_W-1:0] rem;
    logic [ISQRT_X_W-1:0]   xrem;
  } isqrt_stage_t;
  // Consumes the top two radicand bits; xrem is left-aligned so the next pair is always on top
  function automatic isqrt_stage_t isqrt_step(isqrt_stage_t s);
    isqrt_stage_t n;
    logic [ISQRT_REM_W-1:0] rem;
    logic [ISQRT_REM_W-1:0] trial;
    logic ge;
    rem = (s.rem << 2) | ISQRT_REM_W'(s.xrem[ISQRT_X_W-1 -: 2]);
    trial = {s.root, 2'b01};
    ge = rem >= trial;
    n.root = (s.root << 1) | ISQRT_Y_W'(ge);
    n.rem = ge ? rem - trial : rem;
    n.xrem = s.xrem << 2;
    return n;
  endfunction
endpackage

// File: rtl/isqrt_pipe_if.sv
// isqrt_pipe_if: argument/result bus between the formula FSMs and the root pipeline
interface isqrt_pipe_if;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld;
  logic [15:0] y;
  modport master (output x_vld, x, input y_vld, y);
  modport slave (input x_vld, x, output y_vld, y);
endinterface

// File: rtl/isqrt_stage.sv
// isqrt_stage: ITERS combinational root iterations followed by one register slice
module isqrt_stage
  import isqrt_pkg::*;
#(
  parameter int ITERS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_i,
  input  isqrt_stage_t s_i,
  output logic         vld_o,
  output isqrt_stage_t s_o
);
  isqrt_stage_t s_d, s_q;
  logic vld_q;
  always_comb begin
    s_d = s_i;
    for (int i = 0; i < ITERS; i++) s_d = isqrt_step(s_d);
  end
  // Data loads only with a valid argument so the output holds between results
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= 1'b0;
      s_q   <= '0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) s_q <= s_d;
    end
  end
  assign vld_o = vld_q;
  assign s_o   = s_q;
endmodule

// File: rtl/isqrt_pipe.sv
// isqrt_pipe: fully pipelined floor(sqrt(x)), 32-bit in, 16-bit out, latency N_STAGES
module isqrt_pipe
  import isqrt_pkg::*;
#(
  parameter int N_STAGES = 4
) (
  input logic         clk,
  input logic         rst,
  isqrt_pipe_if.slave bus
);
  localparam int ITERS = N_STAGES > 0 ? 16 / N_STAGES : 1;
  if (N_STAGES < 1 || N_STAGES > 16 || 16 % N_STAGES != 0) begin : g_bad
    $fatal(1, "isqrt_pipe: N_STAGES=%0d must divide 16", N_STAGES);
  end
  isqrt_stage_t st [N_STAGES+1];
  logic vld [N_STAGES+1];
  logic unused_tail;
  assign st[0]  = '{root: '0, rem: '0, xrem: bus.x};
  assign vld[0] = bus.x_vld;
  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    isqrt_stage #(.ITERS(ITERS)) u_stage (
      .clk  (clk),
      .rst  (rst),
      .vld_i(vld[k]),
      .s_i  (st[k]),
      .vld_o(vld[k+1]),
      .s_o  (st[k+1])
    );
  end
  assign bus.y_vld = vld[N_STAGES];
  assign bus.y     = st[N_STAGES].root;
  // Final remainder and drained radicand are not part of the result
  assign unused_tail = ^{st[N_STAGES].rem, st[N_STAGES].xrem};
endmodule

// File: tb/tb_isqrt_pipe.sv
// tb_isqrt_pipe: drives N_STAGES=1,4,16 pipelines in parallel against a history-based sqrt model
module tb_isqrt_pipe;
  localparam int MAXC = 16384;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x_vld = 1'b0;
  logic [31:0] x = '0;
  always #5 clk = ~clk;

  isqrt_pipe_if if1 ();
  isqrt_pipe_if if4 ();
  isqrt_pipe_if if16 ();
  assign if1.x_vld = x_vld;
  assign if1.x = x;
  assign if4.x_vld = x_vld;
  assign if4.x = x;
  assign if16.x_vld = x_vld;
  assign if16.x = x;

  isqrt_pipe #(.N_STAGES(1))  u1  (.clk(clk), .rst(rst), .bus(if1));
  isqrt_pipe #(.N_STAGES(4))  u4  (.clk(clk), .rst(rst), .bus(if4));
  isqrt_pipe #(.N_STAGES(16)) u16 (.clk(clk), .rst(rst), .bus(if16));

  int comps = 0;
  int fails = 0;
  int e = 0;
  logic        h_vld [MAXC];
  logic [31:0] h_x   [MAXC];
  logic        h_rst [MAXC];
  logic [15:0] yexp  [3];

  function automatic int lat(int n);
    return n == 0 ? 1 : n == 1 ? 4 : 16;
  endfunction

  function automatic logic [15:0] ref_sqrt(logic [31:0] v);
    longint r;
    longint lv;
    lv = longint'(v);
    r = longint'($floor($sqrt(real'(lv))));
    while (r * r > lv) r--;
    while ((r + 1) * (r + 1) <= lv) r++;
    return r[15:0];
  endfunction

  // Expected output after edge e: the argument sampled L-1 edges earlier, unless any reset hit its window
  task automatic check(string tag, logic got_v, logic [15:0] got_y, int n);
    int L;
    logic ev;
    L = lat(n);
    ev = 1'b0;
    if (e >= L - 1) begin
      ev = h_vld[e-L+1];
      for (int j = e - L + 1; j <= e; j++) if (!h_rst[j]) ev = 1'b0;
    end
    if (!h_rst[e]) yexp[n] = '0;
    else if (ev) yexp[n] = ref_sqrt(h_x[e-L+1]);
    comps++;
    assert (got_v === ev) else begin
      fails++;
      $error("FAIL %s_vld N=%0d edge=%0d got=%b exp=%b", tag, L, e, got_v, ev);
    end
    comps++;
    assert (got_y === yexp[n]) else begin
      fails++;
      $error("FAIL %s_y N=%0d edge=%0d got=%0d exp=%0d", tag, L, e, got_y, yexp[n]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (e >= MAXC) begin
      $display("FAIL cycle_budget edge=%0d limit=%0d", e, MAXC);
      $fatal(1, "history exhausted");
    end
    h_vld[e] = x_vld;
    h_x[e] = x;
    h_rst[e] = rst;
    #1;
    check("n1", if1.y_vld, if1.y, 0);
    check("n4", if4.y_vld, if4.y, 1);
    check("n16", if16.y_vld, if16.y, 2);
    e++;
  endtask

  task automatic expect4(string tag, logic v, logic [15:0] y);
    comps++;
    assert (if4.y_vld === v) else begin
      fails++;
      $error("FAIL %s_vld got=%b exp=%b", tag, if4.y_vld, v);
    end
    comps++;
    assert (if4.y === y) else begin
      fails++;
      $error("FAIL %s_y got=%0d exp=%0d", tag, if4.y, y);
    end
  endtask

  logic [31:0] sv_x [6] = '{32'd0, 32'd1, 32'd15, 32'd16, 32'd1_000_000, 32'hFFFF_FFFF};
  logic [15:0] sv_y [6] = '{16'd0, 16'd1, 16'd3, 16'd4, 16'd1000, 16'hFFFF};
  logic        bv   [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] bx   [7] = '{32'd49, 32'd999, 32'd64, 32'd81, 32'd7, 32'd7, 32'd2};
  logic [15:0] by   [7] = '{16'd7, 16'd7, 16'd8, 16'd9, 16'd9, 16'd9, 16'd1};

  initial begin
    logic [31:0] s;
    // reset held with a valid argument present
    rst = 1'b0;
    x_vld = 1'b1;
    x = 32'd100;
    repeat (3) begin
      tick();
      expect4("rst_hold", 1'b0, 16'd0);
    end
    rst = 1'b1;
    x_vld = 1'b0;
    repeat (4) begin
      tick();
      expect4("rst_rel", 1'b0, 16'd0);
    end
    repeat (12) tick();
    // isolated values with exact latency
    for (int i = 0; i < 6; i++) begin
      x = sv_x[i];
      x_vld = 1'b1;
      tick();
      x_vld = 1'b0;
      repeat (2) tick();
      expect4("single_pre", 1'b0, i == 0 ? 16'd0 : sv_y[i-1]);
      tick();
      expect4("single", 1'b1, sv_y[i]);
      repeat (16) tick();
    end
    // back-to-back
    x_vld = 1'b1;
    x = 32'd16;
    tick();
    x = 32'd25;
    tick();
    x = 32'd1_000_000;
    tick();
    x_vld = 1'b0;
    tick();
    expect4("b2b0", 1'b1, 16'd4);
    tick();
    expect4("b2b1", 1'b1, 16'd5);
    tick();
    expect4("b2b2", 1'b1, 16'd1000);
    tick();
    expect4("b2b_end", 1'b0, 16'd1000);
    repeat (16) tick();
    // bubbles: same spacing out as in, y holds between pulses
    for (int i = 0; i < 10; i++) begin
      x_vld = i < 7 ? bv[i] : 1'b0;
      x = i < 7 ? bx[i] : 32'd0;
      tick();
      if (i >= 3) expect4("bubble", bv[i-3], by[i-3]);
    end
    x_vld = 1'b0;
    repeat (16) tick();
    // reset mid-flight discards in-flight arguments
    x_vld = 1'b1;
    x = 32'd9;
    tick();
    x = 32'd16;
    tick();
    x_vld = 1'b0;
    tick();
    rst = 1'b0;
    x_vld = 1'b1;
    x = 32'd4;
    tick();
    expect4("mid_rst", 1'b0, 16'd0);
    rst = 1'b1;
    x_vld = 1'b0;
    repeat (4) begin
      tick();
      expect4("mid_rst_after", 1'b0, 16'd0);
    end
    x_vld = 1'b1;
    x = 32'd36;
    tick();
    x_vld = 1'b0;
    repeat (3) tick();
    expect4("post_rst", 1'b1, 16'd6);
    repeat (16) tick();
    // random traffic, with square-adjacent values and rare resets
    for (int i = 0; i < 10000; i++) begin
      x_vld = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        s = 32'($urandom_range(1, 65535));
        x = s * s - 32'($urandom_range(0, 1));
      end else begin
        x = $urandom;
      end
      rst = $urandom_range(0, 499) != 0;
      tick();
    end
    rst = 1'b1;
    x_vld = 1'b0;
    repeat (20) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end
endmodule
